dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - the core's load/store path (port c_*)
  - a debug/loader port (port d_*) that preloads or inspects data memory.
- Sequences each access over a fixed-latency memory with a small FSM.
- Routes read data back to the owning requester.
- Generates a stall for the core while its access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from issue to valid m_rdata; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- c_req  input  1  core access request.
- c_we  input  1  core write enable; 0 = read.
- c_funct3  input  3  access size/sign, passed through to memory.
- c_addr  input  ADDR_W  core address.
- c_wdata  input  DATA_W  core write data.
- c_gnt  output  1  one-cycle pulse: core request accepted.
- c_rvalid  output  1  one-cycle pulse: core access complete.
- c_rdata  output  DATA_W  core read data.
- d_req, d_we, d_funct3, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the c_* ports, for the debug requester.
- m_read  output  1  memory read strobe.
- m_write  output  1  memory write strobe.
- m_funct3  output  3  memory size/sign.
- m_addr  output  ADDR_W  memory address.
- m_wdata  output  DATA_W  memory write data.
- m_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after issue.
- stall  output  1  core hold: c_req & ~c_rvalid, combinational.

Behaviour:

Reset (asynchronous, whenever rst=1):
- FSM state = IDLE; last_owner = DEBUG.
- All outputs 0; c_rdata and d_rdata 0; latched request fields 0.
- stall follows its equation.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- Requests are sampled only in this state.
- Winner selection:
  - if only one req is high, that requester wins;
  - if both are high, the requester != last_owner wins (round-robin).
- At the edge:
  - latch we, funct3, addr, wdata and owner;
  - last_owner <= winner;
  - cnt <= MEM_LAT-1;
  - state -> ACCESS.
- No req: stay in IDLE.

ACCESS (lasts exactly MEM_LAT cycles):
- Owner's gnt = 1 in the first ACCESS cycle only.
- m_addr, m_funct3, m_wdata = latched values. They hold their last values in IDLE and DONE.
- m_read = ~we for all ACCESS cycles.
- m_write = we in the first ACCESS cycle only; exactly one write strobe per transaction.
- cnt decrements each cycle.
- At the edge where cnt==0:
  - if read, capture m_rdata into the owner's rdata register;
  - state -> DONE.
- Writes leave rdata unchanged.

DONE (one cycle):
- Owner's rvalid = 1.
- No memory strobes.
- state -> IDLE unconditionally.

Latency and throughput:
- req first seen in IDLE at cycle T: gnt at T+1, rvalid at T+MEM_LAT+1.
- Maximum throughput is one transaction per MEM_LAT+2 cycles.

Requester contract:
- Hold req and its fields stable until the rvalid cycle.
- req high in the cycle after rvalid starts a new transaction.
- If req is dropped after being sampled, the transaction still completes and rvalid still pulses.
- Request field changes after sampling are ignored.

Other rules:
- rdata registers hold their value until the next read completion for the same requester.
- The non-owner's gnt and rvalid stay 0 throughout another requester's transaction.
- Reset mid-transaction: the pending access is abandoned, no strobe is issued after reset, and no rvalid is produced for it.
- stall is high from the cycle c_req rises through the cycle before c_rvalid. It is low in the c_rvalid cycle so the core advances on that edge.

Test Plan:
1. Core read, MEM_LAT=2.
   - Stimulus: c_req=1, c_we=0, c_addr=0x10 at cycle 0; memory returns 0xDEADBEEF.
   - Required: c_gnt at cycle 1; m_read cycles 1-2 with m_addr=0x10; c_rvalid at cycle 3 with c_rdata=0xDEADBEEF; stall=1 cycles 0-2 and 0 at cycle 3.
2. Debug write.
   - Stimulus: d_we=1, d_addr=0x20, d_wdata=0x00001234, d_funct3=3'b010.
   - Required: m_write high for exactly one cycle with those values; m_read never high; d_rvalid 3 cycles after the request; d_rdata unchanged; c_* outputs stay 0.
3. Contention, both req held continuously from reset release.
   - Required: transactions alternate core, debug, core, debug.
   - Grants at cycles 1, 5, 9, 13; rvalids at cycles 3, 7, 11, 15.
4. Reset mid-write.
   - Stimulus: assert rst in the second ACCESS cycle of a write.
   - Required: all outputs 0 immediately; no further m_write. After release, a new core read is served with normal timing and core wins the first tie.
5. MEM_LAT=1 boundary.
   - Stimulus: core read at T.
   - Required: gnt and a single m_read cycle at T+1; rvalid at T+2 with data captured from m_rdata at T+1.
6. Req dropped after sampling.
   - Stimulus: c_req high only at cycle 0.
   - Required: transaction completes; c_rvalid pulses at cycle MEM_LAT+1; FSM returns to IDLE; no further grants.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [2:0]        c_funct3;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_read;
    logic              m_write;
    logic [2:0]        m_funct3;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              stall;

    modport slave (
        input  c_req, c_we, c_funct3, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_funct3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_read, m_write, m_funct3, m_addr, m_wdata,
        input  m_rdata,
        output stall
    );

    modport master (
        output c_req, c_we, c_funct3, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_funct3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_read, m_write, m_funct3, m_addr, m_wdata,
        output m_rdata,
        input  stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port between the core and the debug loader.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE; read data is steered to the owner's register.
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE  = 1'b0,
        OWN_DEBUG = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    req_t              req_q, req_d;

    logic              c_gnt_q, c_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    req_t              c_fields;
    req_t              d_fields;
    owner_t            winner;
    logic              any_req;

    // Winner selection: a lone requester wins; on a tie the one that did not go last wins.
    always_comb begin : winner_sel
        c_fields = {bus.c_we, bus.c_funct3, bus.c_addr, bus.c_wdata};
        d_fields = {bus.d_we, bus.d_funct3, bus.d_addr, bus.d_wdata};
        any_req  = bus.c_req | bus.d_req;
        if (bus.c_req && bus.d_req) begin
            winner = (last_owner_q == OWN_CORE) ? OWN_DEBUG : OWN_CORE;
        end else if (bus.d_req) begin
            winner = OWN_DEBUG;
        end else begin
            winner = OWN_CORE;
        end
    end

    // Next state plus the next value of every registered strobe.
    always_comb begin : fsm_next
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        req_d        = req_q;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
        c_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;
        c_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        m_read_d     = 1'b0;
        m_write_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = ACCESS;
                    owner_d      = winner;
                    last_owner_d = winner;
                    req_d        = (winner == OWN_DEBUG) ? d_fields : c_fields;
                    cnt_d        = CNT_LOAD;
                    c_gnt_d      = (winner == OWN_CORE);
                    d_gnt_d      = (winner == OWN_DEBUG);
                    m_read_d     = ~req_d.we;
                    m_write_d    = req_d.we;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!req_q.we) begin
                        if (owner_q == OWN_CORE) begin
                            c_rdata_d = bus.m_rdata;
                        end else begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end
                    c_rvalid_d = (owner_q == OWN_CORE);
                    d_rvalid_d = (owner_q == OWN_DEBUG);
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    m_read_d = ~req_q.we;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_CORE;
            last_owner_q <= OWN_DEBUG;
            req_q        <= '0;
            c_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            c_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            req_q        <= req_d;
            c_gnt_q      <= c_gnt_d;
            d_gnt_q      <= d_gnt_d;
            c_rvalid_q   <= c_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.c_gnt    = c_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.m_read   = m_read_q;
    assign bus.m_write  = m_write_q;
    // Address/size/data come straight from the latched request, so they hold between accesses.
    assign bus.m_funct3 = req_q.funct3;
    assign bus.m_addr   = req_q.addr;
    assign bus.m_wdata  = req_q.wdata;
    // Low in the rvalid cycle so the core advances on that edge.
    assign bus.stall    = bus.c_req & ~c_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model
// (round-robin winner, fixed cycle offsets, reference memory image).
module tb_dmem_arbiter;
    localparam int LAT = 2;
    localparam logic [31:0] KEY1 = 32'h5A5A_0F0F;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tb_req_t;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int rd_run = 0;
    int rd_run1 = 0;
    int wr_seen = 0;
    bit last_dbg;
    logic [31:0] exp_c_rdata;
    logic [31:0] exp_d_rdata;

    // Memory behind the MEM_LAT=2 arbiter: data only on the last cycle of a read burst, noise otherwise.
    always @(negedge clk) begin
        if (rst || !bus.m_read) rd_run = 0;
        else rd_run++;
        if (bus.m_read && rd_run == LAT) bus.m_rdata = mem[bus.m_addr[5:2]];
        else bus.m_rdata = $urandom();
        if (bus.m_write && !rst) begin
            mem[bus.m_addr[5:2]] = bus.m_wdata;
            wr_seen++;
        end
    end

    // Memory behind the MEM_LAT=1 arbiter: returns an address-derived word in the single read cycle.
    always @(negedge clk) begin
        if (rst || !bus1.m_read) rd_run1 = 0;
        else rd_run1++;
        if (bus1.m_read && rd_run1 == 1) bus1.m_rdata = bus1.m_addr ^ KEY1;
        else bus1.m_rdata = $urandom();
    end

    function automatic tb_req_t rnd_req();
        tb_req_t r;
        r.we     = 1'($urandom_range(0, 1));
        r.funct3 = 3'($urandom());
        r.addr   = 32'($urandom_range(0, 15)) << 2;
        r.wdata  = $urandom();
        return r;
    endfunction

    task automatic do_reset();
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_dbg = 1'b1;
        exp_c_rdata = '0;
        exp_d_rdata = '0;
    endtask

    // One complete transaction starting in an IDLE cycle; checks every cycle through rvalid.
    task automatic do_txn(input bit cr, input bit dr, input tb_req_t cq, input tb_req_t dq,
                          input bit drop, input string tag);
        bit win_d;
        tb_req_t w;
        int wr0;
        bit eg, ev, er, ew;
        logic [6:0] exp_s, got_s;
        if (cr && dr) win_d = !last_dbg;
        else win_d = dr;
        last_dbg = win_d;
        w = win_d ? dq : cq;
        bus.c_req = cr; bus.c_we = cq.we; bus.c_funct3 = cq.funct3; bus.c_addr = cq.addr; bus.c_wdata = cq.wdata;
        bus.d_req = dr; bus.d_we = dq.we; bus.d_funct3 = dq.funct3; bus.d_addr = dq.addr; bus.d_wdata = dq.wdata;
        wr0 = wr_seen;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 1 && drop) begin
                bus.c_req = 1'b0;
                bus.d_req = 1'b0;
            end
            @(negedge clk);
            eg = (k == 1);
            ev = (k == LAT + 1);
            er = !w.we && k >= 1 && k <= LAT;
            ew = w.we && k == 1;
            exp_s = {eg && !win_d, eg && win_d, ev && !win_d, ev && win_d, er, ew, bus.c_req && !(ev && !win_d)};
            got_s = {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.m_read, bus.m_write, bus.stall};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL %s strobes cycle %0d: got %b want %b (c_gnt d_gnt c_rvalid d_rvalid m_read m_write stall)",
                         tag, k, got_s, exp_s);
            end
            if (k >= 1 && k <= LAT) begin
                checks++;
                if ({bus.m_funct3, bus.m_addr, bus.m_wdata} !== {w.funct3, w.addr, w.wdata}) begin
                    errors++;
                    $display("FAIL %s mem fields cycle %0d: got f3=%h addr=%h wdata=%h want f3=%h addr=%h wdata=%h",
                             tag, k, bus.m_funct3, bus.m_addr, bus.m_wdata, w.funct3, w.addr, w.wdata);
                end
            end
        end
        @(posedge clk);
        #1;
        if (w.we) ref_mem[w.addr[5:2]] = w.wdata;
        else if (win_d) exp_d_rdata = ref_mem[w.addr[5:2]];
        else exp_c_rdata = ref_mem[w.addr[5:2]];
        checks++;
        if ({bus.c_rdata, bus.d_rdata} !== {exp_c_rdata, exp_d_rdata}) begin
            errors++;
            $display("FAIL %s rdata: got c=%h d=%h want c=%h d=%h", tag, bus.c_rdata, bus.d_rdata,
                     exp_c_rdata, exp_d_rdata);
        end
        checks++;
        if (wr_seen - wr0 !== (w.we ? 1 : 0)) begin
            errors++;
            $display("FAIL %s write strobes: got %0d want %0d", tag, wr_seen - wr0, w.we ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        logic [6:0] got_s;
        @(posedge clk);
        #1;
        bus.c_req = 1'b1;
        #1;
        got_s = {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.m_read, bus.m_write, bus.stall};
        checks++;
        if (got_s !== 7'b0000001) begin
            errors++;
            $display("FAIL reset strobes: got %b want %b", got_s, 7'b0000001);
        end
        checks++;
        if ({bus.m_funct3, bus.m_addr, bus.m_wdata, bus.c_rdata, bus.d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset data: got addr=%h wdata=%h c_rdata=%h d_rdata=%h want all 0",
                     bus.m_addr, bus.m_wdata, bus.c_rdata, bus.d_rdata);
        end
        bus.c_req = 1'b0;
        #1;
        checks++;
        if ({bus.stall, bus1.c_gnt, bus1.c_rvalid, bus1.m_read, bus1.m_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset idle: got stall=%b lat1 strobes=%b%b%b%b want 0", bus.stall,
                     bus1.c_gnt, bus1.c_rvalid, bus1.m_read, bus1.m_write);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_dbg = 1'b1;
        exp_c_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic test_core_read();
        mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        do_txn(1'b1, 1'b0, tb_req_t'{we: 1'b0, funct3: 3'b010, addr: 32'h10, wdata: 32'h0}, rnd_req(), 1'b0, "core_read");
        checks++;
        if (bus.c_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL core_read value: got %h want %h", bus.c_rdata, 32'hDEAD_BEEF);
        end
        bus.c_req = 1'b0;
    endtask

    task automatic test_debug_write();
        do_txn(1'b0, 1'b1, rnd_req(), tb_req_t'{we: 1'b1, funct3: 3'b010, addr: 32'h20, wdata: 32'h0000_1234},
               1'b0, "debug_write");
        checks++;
        if (mem[8] !== 32'h0000_1234) begin
            errors++;
            $display("FAIL debug_write memory: got %h want %h", mem[8], 32'h0000_1234);
        end
        bus.d_req = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, rnd_req(), rnd_req(), 1'b0, "contention");
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] wd;
        int wr0;
        logic [6:0] got_s;
        wd = $urandom();
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_funct3 = 3'b001; bus.c_addr = 32'h30; bus.c_wdata = wd;
        bus.d_req = 1'b0;
        wr0 = wr_seen;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.m_write} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid first access: got gnt=%b m_write=%b want 1 1", bus.c_gnt, bus.m_write);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        got_s = {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.m_read, bus.m_write, bus.stall};
        checks++;
        if (got_s !== 7'b0000001) begin
            errors++;
            $display("FAIL rst_mid strobes: got %b want %b", got_s, 7'b0000001);
        end
        checks++;
        if ({bus.m_funct3, bus.m_addr, bus.m_wdata, bus.c_rdata, bus.d_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid data: got addr=%h wdata=%h c_rdata=%h want 0", bus.m_addr, bus.m_wdata, bus.c_rdata);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.m_write, bus.m_read, bus.c_rvalid} !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid held: got m_write=%b m_read=%b c_rvalid=%b want 0", bus.m_write,
                         bus.m_read, bus.c_rvalid);
            end
        end
        checks++;
        if (wr_seen - wr0 !== 1) begin
            errors++;
            $display("FAIL rst_mid write count: got %0d want 1", wr_seen - wr0);
        end
        ref_mem[12] = wd;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_dbg = 1'b1;
        exp_c_rdata = '0;
        exp_d_rdata = '0;
        do_txn(1'b1, 1'b1, tb_req_t'{we: 1'b0, funct3: 3'b010, addr: 32'h30, wdata: 32'h0}, rnd_req(), 1'b0,
               "post_reset_read");
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic test_mem_lat1();
        logic [31:0] a;
        logic [4:0] exp_s, got_s;
        for (int n = 0; n < 3; n++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            bus1.c_req = 1'b1; bus1.c_we = 1'b0; bus1.c_funct3 = 3'b010; bus1.c_addr = a;
            bus1.c_wdata = $urandom();
            for (int k = 0; k <= 2; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                exp_s = {k == 1, k == 2, k == 1, 1'b0, k != 2};
                got_s = {bus1.c_gnt, bus1.c_rvalid, bus1.m_read, bus1.m_write, bus1.stall};
                checks++;
                if (got_s !== exp_s) begin
                    errors++;
                    $display("FAIL lat1 strobes cycle %0d: got %b want %b (gnt rvalid m_read m_write stall)",
                             k, got_s, exp_s);
                end
                if (k == 1) begin
                    checks++;
                    if (bus1.m_addr !== a) begin
                        errors++;
                        $display("FAIL lat1 m_addr: got %h want %h", bus1.m_addr, a);
                    end
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus1.c_rdata !== (a ^ KEY1)) begin
                errors++;
                $display("FAIL lat1 rdata: got %h want %h", bus1.c_rdata, a ^ KEY1);
            end
        end
        bus1.c_req = 1'b0;
    endtask

    task automatic test_req_drop();
        do_txn(1'b1, 1'b0, tb_req_t'{we: 1'b0, funct3: 3'b100, addr: 32'h4, wdata: 32'h0}, rnd_req(), 1'b1, "req_drop");
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.m_read, bus.m_write, bus.stall} !== 6'b0) begin
                errors++;
                $display("FAIL req_drop idle cycle %0d: got gnt=%b rvalid=%b m_read=%b m_write=%b stall=%b want 0",
                         k, bus.c_gnt, bus.c_rvalid, bus.m_read, bus.m_write, bus.stall);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int sel;
        bit cr, dr, drop;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(1, 3));
            cr = (sel & 1) != 0;
            dr = (sel & 2) != 0;
            drop = ($urandom_range(0, 4) == 0);
            do_txn(cr, dr, rnd_req(), rnd_req(), drop, "random");
            if ($urandom_range(0, 3) == 0) begin
                bus.c_req = 1'b0;
                bus.d_req = 1'b0;
                @(negedge clk);
                checks++;
                if ({bus.c_gnt, bus.d_gnt, bus.m_read, bus.m_write, bus.stall} !== 5'b0) begin
                    errors++;
                    $display("FAIL random idle gap: got gnt=%b%b m_read=%b m_write=%b stall=%b want 0",
                             bus.c_gnt, bus.d_gnt, bus.m_read, bus.m_write, bus.stall);
                end
                @(posedge clk);
                #1;
            end
        end
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_funct3 = '0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_funct3 = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus1.c_req = 1'b0; bus1.c_we = 1'b0; bus1.c_funct3 = '0; bus1.c_addr = '0; bus1.c_wdata = '0;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_funct3 = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom();
            ref_mem[i] = mem[i];
        end
        last_dbg = 1'b1;
        exp_c_rdata = '0;
        exp_d_rdata = '0;

        test_reset();
        test_core_read();
        test_debug_write();
        test_contention();
        test_reset_mid_write();
        test_mem_lat1();
        test_req_drop();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
